// File: rtl/l1_dm_lfe.sv
// L1 data-cache line fill engine: dirty-victim writeback read-out, then refill writes into the same set.
// Optional macro L1_DM_LFE_CRIT_FIRST_EN adds req_off/crit_val for critical-word-first refill order.
module l1_dm_lfe #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 1024,
  parameter  int unsigned BEATS = 8,
  localparam int unsigned IDXW  = $clog2(DEPTH / BEATS),
  localparam int unsigned OFFW  = $clog2(BEATS),
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [IDXW-1:0]  req_idx,
  input  logic             req_dirty,
`ifdef L1_DM_LFE_CRIT_FIRST_EN
  input  logic [OFFW-1:0]  req_off,
  output logic             crit_val,
`endif
  output logic             wb_val,
  input  logic             wb_rdy,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_last,
  input  logic             fill_val,
  output logic             fill_rdy,
  input  logic [WIDTH-1:0] fill_data,
  input  logic             fill_last,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {S_IDLE, S_EVICT, S_DRAIN, S_FILL, S_DONE} state_t;

  state_t           state, state_nx;
  logic [IDXW-1:0]  idx_q;
  logic [OFFW-1:0]  rd_cnt, wb_cnt, fill_cnt, beat_addr;
  logic [WIDTH-1:0] fifo_q [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       fifo_cnt, occ;
  logic             inflight, mismatch;
  logic             wb_pop, rd_issue, fill_acc, req_acc;
  logic             fill_end;

`ifdef L1_DM_LFE_CRIT_FIRST_EN
  logic [OFFW-1:0]  off_q;
  assign beat_addr = OFFW'(off_q + fill_cnt);
`else
  assign beat_addr = fill_cnt;
`endif

  // Writeback FIFO head drives the WB channel; head is stable until popped.
  assign wb_val   = (fifo_cnt != 2'd0);
  assign wb_data  = fifo_q[rd_ptr];
  assign wb_last  = (wb_cnt == OFFW'(BEATS - 1));
  assign wb_pop   = wb_val & wb_rdy;
  assign occ      = 2'(fifo_cnt + {1'b0, inflight});
  assign req_acc  = req_val & req_rdy;
  assign fill_end = (fill_cnt == OFFW'(BEATS - 1));

  always_comb begin
    state_nx  = state;
    req_rdy   = 1'b0;
    fill_rdy  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_issue  = 1'b0;
    fill_acc  = 1'b0;
`ifdef L1_DM_LFE_CRIT_FIRST_EN
    crit_val  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        req_rdy = 1'b1;
        busy    = 1'b0;
        if (req_val) state_nx = req_dirty ? S_EVICT : S_FILL;
      end
      S_EVICT: begin
        // A read may issue when a FIFO slot is free after this cycle's pop.
        if ((occ < 2'd2) || wb_pop) begin
          rd_issue = 1'b1;
          mem_en   = 1'b1;
          mem_addr = {idx_q, rd_cnt};
          if (rd_cnt == OFFW'(BEATS - 1)) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (wb_pop && wb_last) state_nx = S_FILL;
      end
      S_FILL: begin
        fill_rdy = 1'b1;
        if (fill_val) begin
          fill_acc  = 1'b1;
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {idx_q, beat_addr};
          mem_wdata = fill_data;
`ifdef L1_DM_LFE_CRIT_FIRST_EN
          crit_val  = (fill_cnt == '0);
`endif
          if (fill_end) state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        err      = mismatch;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx_q    <= '0;
      rd_cnt   <= '0;
      wb_cnt   <= '0;
      fill_cnt <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      inflight <= 1'b0;
      mismatch <= 1'b0;
`ifdef L1_DM_LFE_CRIT_FIRST_EN
      off_q    <= '0;
`endif
    end else begin
      state    <= state_nx;
      inflight <= rd_issue;
      fifo_cnt <= 2'(fifo_cnt + {1'b0, inflight} - {1'b0, wb_pop});
      if (inflight) wr_ptr <= ~wr_ptr;
      if (wb_pop) begin
        rd_ptr <= ~rd_ptr;
        wb_cnt <= wb_cnt + OFFW'(1);
      end
      if (rd_issue) rd_cnt <= rd_cnt + OFFW'(1);
      if (fill_acc) begin
        fill_cnt <= fill_cnt + OFFW'(1);
        if (fill_last != fill_end) mismatch <= 1'b1;
      end
      if (state == S_DONE) mismatch <= 1'b0;
      if (req_acc) begin
        idx_q    <= req_idx;
        rd_cnt   <= '0;
        wb_cnt   <= '0;
        fill_cnt <= '0;
`ifdef L1_DM_LFE_CRIT_FIRST_EN
        off_q    <= req_off;
`endif
      end
    end
  end

  // Read data lands in the FIFO the cycle after the array read.
  always_ff @(posedge clk) begin
    if (inflight) fifo_q[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_l1_dm_lfe.sv
// Scoreboard bench for l1_dm_lfe: randomized misses against a line-level reference model and an array model.
module tb_l1_dm_lfe;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned BEATS = 8;
  localparam int unsigned IDXW  = 7;
  localparam int unsigned OFFW  = 3;
  localparam int unsigned AW    = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             req_val = 1'b0, req_rdy, req_dirty = 1'b0;
  logic [IDXW-1:0]  req_idx = '0;
  logic             wb_val, wb_rdy = 1'b0, wb_last;
  logic [WIDTH-1:0] wb_data;
  logic             fill_val = 1'b0, fill_rdy, fill_last = 1'b0;
  logic [WIDTH-1:0] fill_data = '0;
  logic             mem_en, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;
  logic             busy, done, err;
`ifdef L1_DM_LFE_CRIT_FIRST_EN
  logic [OFFW-1:0]  req_off = '0;
  logic             crit_val;
  bit               exp_cv [$];
`endif

  l1_dm_lfe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy), .req_idx(req_idx),
    .req_dirty(req_dirty),
`ifdef L1_DM_LFE_CRIT_FIRST_EN
    .req_off(req_off), .crit_val(crit_val),
`endif
    .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_data(wb_data), .wb_last(wb_last),
    .fill_val(fill_val), .fill_rdy(fill_rdy), .fill_data(fill_data), .fill_last(fill_last),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err));

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int wb_mode = 0;

  logic [WIDTH-1:0]    ref_mem [DEPTH];
  logic [WIDTH:0]      exp_wb [$];
  logic [AW+WIDTH-1:0] exp_wr [$];
  bit                  exp_done [$];
  int                  wb_t [$];
  int                  rd_t [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else passes++;
  endtask

  function automatic logic [WIDTH-1:0] init_word(input int a);
    if (a / BEATS == 3) return WIDTH'(32'h30 + a % BEATS);
    return WIDTH'(a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Single-port array model with one-cycle read latency.
  initial begin
    logic [WIDTH-1:0] sram [DEPTH];
    for (int a = 0; a < DEPTH; a++) sram[a] = init_word(a);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) sram[mem_addr] = mem_wdata;
        else mem_rdata <= sram[mem_addr];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Writeback sink ready pattern.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (wb_mode)
        1: wb_rdy = 1'b1;
        2: wb_rdy = ~wb_rdy;
        3: wb_rdy = 1'b0;
        default: wb_rdy = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compares every observed transfer against the scoreboard queues.
  logic          held = 1'b0;
  logic [WIDTH+1:0] held_v = '0;
  always @(negedge clk) begin
    if (rst) held = 1'b0;
    else begin
      if (held) chk("wb_hold", 64'({wb_val, wb_last, wb_data}), 64'(held_v));
      held   = wb_val && !wb_rdy;
      held_v = {wb_val, wb_last, wb_data};
      if (wb_val && wb_rdy) begin
        wb_t.push_back(cyc);
        if (exp_wb.size() == 0) chk("wb_unexpected", 64'(1), 64'(0));
        else begin
          logic [WIDTH:0] e;
          e = exp_wb.pop_front();
          chk("wb_data", 64'(wb_data), 64'(e[WIDTH-1:0]));
          chk("wb_last", 64'(wb_last), 64'(e[WIDTH]));
        end
      end
      if (mem_en && !mem_we) rd_t.push_back(cyc);
      if (fill_rdy) chk("fill_before_wb_done", 64'(exp_wb.size()), 64'(0));
      if (mem_en && mem_we) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 64'(1), 64'(0));
        else begin
          logic [AW+WIDTH-1:0] e;
          e = exp_wr.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(e[AW+WIDTH-1:WIDTH]));
          chk("wr_data", 64'(mem_wdata), 64'(e[WIDTH-1:0]));
        end
`ifdef L1_DM_LFE_CRIT_FIRST_EN
        if (exp_cv.size() != 0) chk("crit_val", 64'(crit_val), 64'(exp_cv.pop_front()));
`endif
      end
`ifdef L1_DM_LFE_CRIT_FIRST_EN
      if (crit_val && !(mem_en && mem_we)) chk("crit_without_write", 64'(1), 64'(0));
`endif
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", 64'(1), 64'(0));
        else chk("err", 64'(err), 64'(exp_done.pop_front()));
      end else if (err) chk("err_without_done", 64'(1), 64'(0));
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // One miss: push the line-level expectation, issue the request, feed BEATS refill beats.
  task automatic do_miss(input int idx, input bit dirty, input int bad_beat, input int off,
                         input int gap, input int base);
    logic [WIDTH-1:0] fd [BEATS];
    int n;
    n = 0;
    while (!req_rdy) begin
      @(posedge clk); #1;
      if (++n > 200) begin chk("req_rdy_timeout", 64'(0), 64'(1)); return; end
    end
    if (dirty)
      for (int b = 0; b < BEATS; b++)
        exp_wb.push_back({b == BEATS - 1, ref_mem[idx * BEATS + b]});
    for (int i = 0; i < BEATS; i++) begin
      int a;
      fd[i] = (base != 0) ? WIDTH'(base + i) : WIDTH'($urandom);
`ifdef L1_DM_LFE_CRIT_FIRST_EN
      a = idx * BEATS + (off + i) % BEATS;
      exp_cv.push_back(i == 0);
`else
      a = idx * BEATS + i + 0 * off;
`endif
      exp_wr.push_back({AW'(a), fd[i]});
      ref_mem[a] = fd[i];
    end
    exp_done.push_back(bad_beat >= 0);
    req_val = 1'b1; req_idx = IDXW'(idx); req_dirty = dirty;
`ifdef L1_DM_LFE_CRIT_FIRST_EN
    req_off = OFFW'(off);
`endif
    @(posedge clk); #1;
    req_val = 1'b0; req_idx = IDXW'($urandom); req_dirty = 1'($urandom);
    for (int i = 0; i < BEATS; i++) begin
      if (gap > 0) begin
        repeat ($urandom_range(0, gap)) @(posedge clk);
        #1;
      end
      fill_val = 1'b1; fill_data = fd[i];
      fill_last = (i == BEATS - 1) ^ (i == bad_beat);
      n = 0;
      @(negedge clk);
      while (!fill_rdy) begin
        if (++n > 400) begin chk("fill_rdy_timeout", 64'(0), 64'(1)); fill_val = 1'b0; return; end
        @(negedge clk);
      end
      @(posedge clk); #1;
      fill_val = 1'b0; fill_last = 1'b0;
    end
    @(negedge clk);
    chk("done_after_last_beat", 64'(done), 64'(1));
    @(negedge clk);
    chk("req_rdy_after_done", 64'(req_rdy), 64'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_word(a);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_rdy", 64'(req_rdy), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_wb_val", 64'(wb_val), 64'(0));
    chk("rst_mem_en", 64'(mem_en), 64'(0));
    chk("rst_fill_rdy", 64'(fill_rdy), 64'(0));
    chk("rst_done_err", 64'({done, err}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean miss, back-to-back beats 0xA0..0xA7 into set 5.
    wb_mode = 1;
    do_miss(5, 1'b0, -1, 0, 0, 32'hA0);

    // Dirty miss with toggling writeback sink; set 3 holds 0x30..0x37.
    wb_mode = 2;
    do_miss(3, 1'b1, -1, 0, 0, 0);

    // Full-rate writeback.
    wb_mode = 1;
    wb_t.delete(); rd_t.delete();
    do_miss(11, 1'b1, -1, 0, 0, 0);
    chk("fullrate_rd_count", 64'(rd_t.size()), 64'(BEATS));
    chk("fullrate_wb_count", 64'(wb_t.size()), 64'(BEATS));
    if (rd_t.size() == BEATS) chk("fullrate_rd_span", 64'(rd_t[BEATS-1] - rd_t[0]), 64'(BEATS - 1));
    if (wb_t.size() == BEATS) chk("fullrate_wb_span", 64'(wb_t[BEATS-1] - wb_t[0]), 64'(BEATS - 1));

    // FILL_LAST asserted early on beat 3.
    wb_mode = 0;
    do_miss(20, 1'b0, 3, 0, 1, 0);

`ifdef L1_DM_LFE_CRIT_FIRST_EN
    do_miss(2, 1'b0, -1, 5, 0, 0);
`endif

    // Reset after three writeback reads of a dirty miss.
    wb_mode = 1;
    for (int b = 0; b < BEATS; b++) exp_wb.push_back({b == BEATS - 1, ref_mem[9 * BEATS + b]});
    rd_t.delete();
    req_val = 1'b1; req_idx = IDXW'(9); req_dirty = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    begin
      int n;
      n = 0;
      while (rd_t.size() < 3 && n < 50) begin @(negedge clk); n++; end
      chk("evict_reads_started", 64'(rd_t.size() >= 3), 64'(1));
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_wb.delete();
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_wb_val", 64'(wb_val), 64'(0));
    chk("mid_rst_mem_en", 64'(mem_en), 64'(0));
    chk("mid_rst_req_rdy", 64'(req_rdy), 64'(1));
    @(posedge clk); #1;
    do_miss(9, 1'b1, -1, 0, 0, 0);

    // Randomized misses.
    for (int t = 0; t < 14; t++) begin
      wb_mode = $urandom_range(0, 2);
      do_miss($urandom_range(0, DEPTH / BEATS - 1), 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, BEATS - 1) : -1,
              $urandom_range(0, BEATS - 1), $urandom_range(0, 2), 0);
    end

    repeat (4) @(posedge clk);
    chk("wb_queue_drained", 64'(exp_wb.size()), 64'(0));
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'(0));
    chk("done_queue_drained", 64'(exp_done.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/l1_dm_lfe.md
Name: l1_dm_lfe

Overview:
- Line fill engine for the L1 data cache. It is the initiator side of the data-memory single-port SRAM interface (EN/ADDR/WE/WDATA/RDATA).
- On a miss it reads out the victim line beat by beat for writeback when the victim is dirty. It then writes the refill beats arriving from the memory side into the same set.
- It sits between the L1 miss controller and the data-memory array. The cache top muxes the array port to this engine while BUSY is high.

Parameters:
- WIDTH, 32, data word width (equals array width).
- DEPTH, 1024, array depth in words.
- BEATS, 8, words per cache line; power of 2, at least 2.
- Derived: IDXW = $clog2(DEPTH/BEATS); OFFW = $clog2(BEATS).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous reset, active high.
- REQ_VAL  in  1  miss request valid.
- REQ_RDY  out  1  engine can accept a request (high only in IDLE).
- REQ_IDX  in  IDXW  set index of the line.
- REQ_DIRTY  in  1  victim is dirty; perform writeback first.
- WB_VAL  out  1  writeback beat valid.
- WB_RDY  in  1  writeback sink ready.
- WB_DATA  out  WIDTH  writeback beat.
- WB_LAST  out  1  final writeback beat.
- FILL_VAL  in  1  refill beat valid.
- FILL_RDY  out  1  engine accepts a refill beat.
- FILL_DATA  in  WIDTH  refill beat.
- FILL_LAST  in  1  sender's last-beat marker (checked only).
- MEM_EN  out  1  array enable.
- MEM_WE  out  1  array write enable.
- MEM_ADDR  out  $clog2(DEPTH)  array address = {idx, beat}.
- MEM_WDATA  out  WIDTH  array write data.
- MEM_RDATA  in  WIDTH  array read data, valid the cycle after an EN & !WE access.
- BUSY  out  1  engine owns the array port.
- DONE  out  1  one-cycle pulse when the line fill completes.
- ERR  out  1  pulse with DONE when a FILL_LAST mismatch was detected.

Behaviour:
- Reset values:
  - All outputs are 0, except REQ_RDY, which is 1.
  - State is IDLE.
  - Writeback FIFO is empty; in-flight read flag is cleared; counters are 0.
  - A read already in flight when RST is asserted is discarded.
  - Reset mid-operation returns to IDLE in the next cycle, with no further array access.
- States: IDLE, EVICT, DRAIN, FILL, DONE.
- IDLE:
  - REQ_VAL & REQ_RDY latches idx and dirty and clears the beat counters.
  - Next state is EVICT if dirty, otherwise FILL.
- EVICT (array read phase):
  - Uses a 2-entry writeback FIFO and a 1-cycle read latency.
  - Read credit = 2 - fifo_count - inflight.
  - A WB pop in the current cycle adds one credit in that same cycle.
  - When credit > 0 and rd_cnt < BEATS: MEM_EN=1, MEM_WE=0, MEM_ADDR={idx, rd_cnt}; rd_cnt increments.
  - MEM_RDATA is pushed into the FIFO the next cycle.
  - Sustains 1 beat per cycle when WB_RDY is held high.
  - After the last read is issued, go to DRAIN.
- DRAIN:
  - No array access.
  - Go to FILL once the final writeback beat has handshaken.
- WB output:
  - WB_VAL = FIFO not empty; WB_DATA = FIFO head.
  - WB_LAST = 1 on beat BEATS-1.
  - WB_DATA and WB_LAST are held stable while WB_VAL & !WB_RDY.
- FILL:
  - FILL_RDY = 1.
  - Each FILL_VAL & FILL_RDY drives MEM_EN=1, MEM_WE=1, MEM_WDATA=FILL_DATA, MEM_ADDR={idx, beat_addr} combinationally in the same cycle.
  - The fill counter increments per accepted beat.
  - After beat BEATS-1 is accepted, go to DONE.
  - No fill beat is accepted during EVICT or DRAIN: writeback always completes before any refill write.
- Beat ordering: beat_addr = fill counter, unless the optional feature is enabled.
- FILL_LAST check:
  - FILL_LAST=1 on any beat other than the final one, or FILL_LAST=0 on the final beat, sets a sticky mismatch flag.
  - Control ignores FILL_LAST: the engine always consumes exactly BEATS beats.
- DONE:
  - Lasts one cycle: DONE=1, ERR=mismatch flag; the flag is cleared.
  - Then return to IDLE.
- BUSY = 1 in every state except IDLE.
- Outside the access cycles above: MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0.
- The engine never drives a read and a write to the array in the same cycle.
- REQ_VAL is ignored outside IDLE.
- Counters wrap modulo BEATS; the line address never crosses the set.

Optional Feature:
- Macro: L1_DM_LFE_CRIT_FIRST_EN.
- When defined:
  - An extra input port REQ_OFF (OFFW bits) is latched with the request.
  - Refill beats are written at beat_addr = (REQ_OFF + fill_cnt) mod BEATS, so the critical word arrives first.
  - An extra output CRIT_VAL pulses for one cycle together with the first accepted fill beat.
  - Writeback order is unchanged (beat 0 first).
- When undefined:
  - Neither port exists.
  - Fill order is beat 0 to BEATS-1.

Test Plan:
- Clean miss: REQ_IDX=5, REQ_DIRTY=0, 8 fill beats 0xA0..0xA7 back-to-back, FILL_LAST on beat 7 -> 8 write cycles to MEM_ADDR 40..47 in consecutive cycles; DONE=1, ERR=0 one cycle after the last beat; REQ_RDY high the following cycle.
- Dirty miss with stalls: array set 3 preloaded with 0x30..0x37, REQ_DIRTY=1, WB_RDY toggling 1/0 -> WB_DATA 0x30..0x37 in order with no loss or duplication; WB_LAST only with 0x37; fifo_count never exceeds 2; FILL_RDY stays 0 until after the 0x37 handshake.
- Full-rate writeback: WB_RDY held 1 -> reads issued on 8 consecutive cycles; 8 WB beats on consecutive cycles.
- FILL_LAST error: FILL_LAST asserted on beat 3 -> all 8 beats still written; ERR=1 with DONE.
- Reset mid-EVICT: RST asserted after 3 reads are issued -> next cycle BUSY=0, WB_VAL=0, MEM_EN=0, REQ_RDY=1; a new request then completes normally.
- With L1_DM_LFE_CRIT_FIRST_EN: REQ_IDX=2, REQ_OFF=5 -> writes to MEM_ADDR 21,22,23,16,17,18,19,20; CRIT_VAL only with the write to 21.
